alu_sequencer: RTL

Command-side driver for the 8-bit accumulator ALU. It buffers operation commands in a 4-entry FIFO and drives the ALU's operand, input-select and output-select lines in a fixed issue/capture sequence. It samples the ALU result and overflow flag and returns each result to the requester over a valid/ready response channel. It sits between the host command source and the ALU, and keeps operation and overflow statistics.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-side driver for the 8-bit accumulator ALU. Commands are queued in
//   a DEPTH-entry FIFO, then each one is walked through a fixed
//   IDLE -> ISSUE -> CAPTURE -> RESP sequence that drives the ALU operand and
//   select lines, samples the ALU result/overflow and returns it on a
//   valid/ready response channel. Keeps op and overflow statistics.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   cmd_valid/ready          command handshake (ready = FIFO not full)
//   cmd_op/acc/a/b           opcode, persist flag, operands
//   alu_num1/num2            operands to ALU
//   alu_in_sel               one-hot {reset, load, persist}
//   alu_out_sel              one-hot operation select (AND..MULT)
//   alu_result/overflow      ALU outputs
//   rsp_valid/ready          response handshake
//   rsp_data/ovf             captured result and overflow
//   state                    current FSM state
//   op_count                 completed ops (wraps)
//   ovf_count                overflowing responses (saturates at 255)
module alu_sequencer #(
  parameter int DEPTH = 4,
  parameter int OPW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic           cmd_acc,
  input  logic [7:0]     cmd_a,
  input  logic [7:0]     cmd_b,
  output logic [7:0]     alu_num1,
  output logic [7:0]     alu_num2,
  output logic [2:0]     alu_in_sel,
  output logic [6:0]     alu_out_sel,
  input  logic [7:0]     alu_result,
  input  logic           alu_overflow,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [7:0]     rsp_data,
  output logic           rsp_ovf,
  output logic [1:0]     state,
  output logic [15:0]    op_count,
  output logic [7:0]     ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
  localparam logic [OPW-1:0] OP_CLR  = OPW'(7);
  localparam logic [2:0]     SEL_PER = 3'b001;
  localparam logic [2:0]     SEL_LD  = 3'b010;
  localparam logic [2:0]     SEL_RST = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_CAPTURE = 2'b10,
    S_RESP    = 2'b11
  } stateT;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic           acc;
    logic [7:0]     a;
    logic [7:0]     b;
  } cmdT;

  cmdT            fifoMem [DEPTH];
  cmdT            head;
  logic [AW-1:0]  wrPtr, rdPtr;
  logic [AW:0]    count;
  logic           push, pop;
  stateT          curState;
  logic [OPW-1:0] opReg;
  logic           capOvf;

  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (curState == S_IDLE) && (count != '0);
  assign head      = fifoMem[rdPtr];
  assign state     = curState;
  // CLR routes through the AND select; its overflow is meaningless.
  assign capOvf    = (opReg != OP_CLR) && alu_overflow;

  function automatic logic [6:0] outSelFor(input logic [OPW-1:0] op);
    if (op == OP_CLR) return 7'b0000001;
    return 7'b0000001 << op;
  endfunction

  function automatic logic [2:0] inSelFor(input cmdT c);
    if (c.op == OP_CLR) return SEL_RST;
    if (c.acc)          return SEL_PER;
    return SEL_LD;
  endfunction

  // Storage has no reset; occupancy is tracked by count/pointers only.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= '{op: cmd_op, acc: cmd_acc, a: cmd_a, b: cmd_b};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState    <= S_IDLE;
      opReg       <= '0;
      alu_num1    <= 8'h00;
      alu_num2    <= 8'h00;
      alu_in_sel  <= SEL_PER;
      alu_out_sel <= 7'b0000000;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_ovf     <= 1'b0;
      op_count    <= 16'h0000;
      ovf_count   <= 8'h00;
    end else begin
      case (curState)
        S_IDLE: begin
          if (pop) begin
            opReg      <= head.op;
            alu_num1   <= head.a;
            alu_num2   <= head.b;
            alu_in_sel <= inSelFor(head);
            curState   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Out select switches only now, so during ISSUE the ALU still
          // presents the previous op's result for persist feedback.
          alu_out_sel <= outSelFor(opReg);
          alu_in_sel  <= SEL_PER;
          curState    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_data  <= alu_result;
          rsp_ovf   <= capOvf;
          rsp_valid <= 1'b1;
          op_count  <= op_count + 16'd1;
          if (capOvf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
          curState  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            curState  <= S_IDLE;
          end
        end
        default: curState <= S_IDLE;
      endcase
    end
  end

endmodule
